gpio_pin_allocator: RTL and testbench

Owns the per-pin core ownership table that drives the GPIO output arbitration: the 2-bit core select per pin plus an owned mask. Four PIO cores submit claim, release, release-all or query requests over a valid/response handshake. A round-robin arbiter serialises the requests and a two-state FSM commits one request at a time. Sits between the PIO cores and the core output arbitrator in the chip top; the top gates pin drive with pin_owned.

---
 rtl/pio_pkg.sv | 21 ++
 rtl/gpio_pin_allocator_if.sv | 23 ++
 rtl/rr_arbiter_4.sv | 27 ++
 rtl/gpio_pin_allocator.sv | 125 ++++++++++++
 tb/tb_gpio_pin_allocator.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/pio_pkg.sv
// Shared constants and types for the GPIO pin allocator.
package pio_pkg;

  localparam int unsigned NUM_CORES  = 4;
  localparam int unsigned NUM_PINS   = 32;
  localparam int unsigned CORE_IDX_W = 2;
  localparam int unsigned PIN_IDX_W  = 5;

  typedef enum logic [1:0] {
    OP_CLAIM       = 2'b00,
    OP_RELEASE     = 2'b01,
    OP_RELEASE_ALL = 2'b10,
    OP_QUERY       = 2'b11
  } op_e;

  typedef enum logic {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } state_e;

endpackage

// File: rtl/gpio_pin_allocator_if.sv
// Request/response bus between the PIO cores and the pin allocator, plus the ownership table outputs.
interface gpio_pin_allocator_if;
  import pio_pkg::*;

  logic [NUM_CORES-1:0]   req_valid;
  logic [2*NUM_CORES-1:0] req_op;
  logic [5*NUM_CORES-1:0] req_pin;
  logic [NUM_CORES-1:0]   resp_valid;
  logic [NUM_CORES-1:0]   resp_ok;
  logic [2*NUM_PINS-1:0]  core_select;
  logic [NUM_PINS-1:0]    pin_owned;

  modport master (
    output req_valid, req_op, req_pin,
    input  resp_valid, resp_ok, core_select, pin_owned
  );

  modport slave (
    input  req_valid, req_op, req_pin,
    output resp_valid, resp_ok, core_select, pin_owned
  );

endinterface

// File: rtl/rr_arbiter_4.sv
// Combinational 4-way round-robin pick; search starts at rr_ptr and wraps 3->0.
module rr_arbiter_4 (
  input  logic [3:0] eligible,
  input  logic [1:0] rr_ptr,
  output logic [3:0] grant_oh,
  output logic [1:0] grant_idx
);

  logic       found;
  logic [1:0] idx;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = rr_ptr + i[1:0];
      if (!found && eligible[idx]) begin
        found         = 1'b1;
        grant_oh[idx] = 1'b1;
        grant_idx     = idx;
      end
    end
  end

endmodule

// File: rtl/gpio_pin_allocator.sv
// Per-pin core ownership table: arbitrates core requests round-robin and commits one op every two cycles.
module gpio_pin_allocator
  import pio_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  gpio_pin_allocator_if.slave bus
);

  state_e                state_q, state_d;
  logic [1:0]            rr_ptr_q, rr_ptr_d;
  logic [CORE_IDX_W-1:0] grant_q, grant_d;
  op_e                   op_q, op_d;
  logic [PIN_IDX_W-1:0]  pin_q, pin_d;
  logic [2*NUM_PINS-1:0] owner_q, owner_d;
  logic [NUM_PINS-1:0]   owned_q, owned_d;
  logic [NUM_CORES-1:0]  resp_valid_q, resp_valid_d;
  logic [NUM_CORES-1:0]  resp_ok_q, resp_ok_d;

  logic [NUM_CORES-1:0]  eligible;
  logic [3:0]            grant_oh;
  logic [1:0]            grant_idx;
  logic [1:0]            cur_owner;
  logic                  owned_by_g;
  logic                  ok;

  // A core's valid may still be high during its own response pulse; do not re-grant it then.
  assign eligible = bus.req_valid & ~resp_valid_q;

  rr_arbiter_4 u_arb (
    .eligible  (eligible),
    .rr_ptr    (rr_ptr_q),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx)
  );

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    op_d         = op_q;
    pin_d        = pin_q;
    owner_d      = owner_q;
    owned_d      = owned_q;
    resp_valid_d = '0;
    resp_ok_d    = '0;
    ok           = 1'b0;
    cur_owner    = owner_q[{pin_q, 1'b0} +: 2];
    owned_by_g   = owned_q[pin_q] && (cur_owner == grant_q);

    case (state_q)
      IDLE: begin
        if (|grant_oh) begin
          grant_d  = grant_idx;
          op_d     = op_e'(bus.req_op[{grant_idx, 1'b0} +: 2]);
          pin_d    = bus.req_pin[5'(grant_idx) * 5'd5 +: 5];
          rr_ptr_d = grant_idx + 2'd1;
          state_d  = COMMIT;
        end
      end
      COMMIT: begin
        case (op_q)
          OP_CLAIM: begin
            if (!owned_q[pin_q] || owned_by_g) begin
              owned_d[pin_q]                = 1'b1;
              owner_d[{pin_q, 1'b0} +: 2]   = grant_q;
              ok                            = 1'b1;
            end
          end
          OP_RELEASE: begin
            if (owned_by_g) begin
              owned_d[pin_q]                = 1'b0;
              owner_d[{pin_q, 1'b0} +: 2]   = '0;
              ok                            = 1'b1;
            end
          end
          OP_RELEASE_ALL: begin
            for (int unsigned p = 0; p < NUM_PINS; p++) begin
              if (owned_q[p[4:0]] && (owner_q[{p[4:0], 1'b0} +: 2] == grant_q)) begin
                owned_d[p[4:0]]                = 1'b0;
                owner_d[{p[4:0], 1'b0} +: 2]   = '0;
              end
            end
            ok = 1'b1;
          end
          default: ok = owned_by_g;
        endcase
        resp_valid_d[grant_q] = 1'b1;
        resp_ok_d[grant_q]    = ok;
        state_d               = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      op_q         <= OP_CLAIM;
      pin_q        <= '0;
      owner_q      <= '0;
      owned_q      <= '0;
      resp_valid_q <= '0;
      resp_ok_q    <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      op_q         <= op_d;
      pin_q        <= pin_d;
      owner_q      <= owner_d;
      owned_q      <= owned_d;
      resp_valid_q <= resp_valid_d;
      resp_ok_q    <= resp_ok_d;
    end
  end

  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_ok     = resp_ok_q;
  assign bus.core_select = owner_q;
  assign bus.pin_owned   = owned_q;

endmodule

// File: tb/tb_gpio_pin_allocator.sv
// Bench for gpio_pin_allocator: ownership-rule model checked every cycle plus directed literal checks.
module tb_gpio_pin_allocator;

  logic clk = 1'b0;
  logic rst = 1'b1;

  gpio_pin_allocator_if bus ();

  gpio_pin_allocator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- model: ownership table plus one request in flight ----------------
  int       m_owner [32];
  bit       m_owned [32];
  bit [3:0] m_rv, m_rok;
  int       m_ptr;
  bit       m_busy;
  int       m_core, m_op, m_pin;

  function automatic bit model_apply(input int g, input int op, input int p);
    bit r;
    r = 1'b0;
    case (op)
      0: if (!m_owned[p] || m_owner[p] == g) begin m_owned[p] = 1; m_owner[p] = g; r = 1; end
      1: if (m_owned[p] && m_owner[p] == g) begin m_owned[p] = 0; m_owner[p] = 0; r = 1; end
      2: begin
        for (int q = 0; q < 32; q++)
          if (m_owned[q] && m_owner[q] == g) begin m_owned[q] = 0; m_owner[q] = 0; end
        r = 1;
      end
      default: r = m_owned[p] && m_owner[p] == g;
    endcase
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int q = 0; q < 32; q++) begin m_owner[q] = 0; m_owned[q] = 0; end
      m_rv = '0; m_rok = '0; m_ptr = 0; m_busy = 0;
    end else if (m_busy) begin
      bit okv;
      okv    = model_apply(m_core, m_op, m_pin);
      m_rv   = '0; m_rok = '0;
      m_rv[m_core]  = 1'b1;
      m_rok[m_core] = okv;
      m_busy = 0;
    end else begin
      logic [3:0] elig;
      elig  = bus.req_valid & ~m_rv;
      m_rv  = '0; m_rok = '0;
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (m_ptr + k) % 4;
        if (!m_busy && elig[c]) begin
          m_busy = 1; m_core = c;
          m_op   = int'(bus.req_op[2*c +: 2]);
          m_pin  = int'(bus.req_pin[5*c +: 5]);
          m_ptr  = (c + 1) % 4;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      logic [63:0] exp_sel;
      logic [31:0] exp_own;
      exp_sel = '0; exp_own = '0;
      for (int q = 0; q < 32; q++) begin
        exp_sel[2*q +: 2] = 2'(m_owner[q]);
        exp_own[q]        = m_owned[q];
      end
      check("cyc_resp_valid", 64'(bus.resp_valid), 64'(m_rv));
      check("cyc_resp_ok", 64'(bus.resp_ok & bus.resp_valid), 64'(m_rok));
      check("cyc_resp_ok_idle", 64'(bus.resp_ok & ~bus.resp_valid), 64'd0);
      check("cyc_core_select", bus.core_select, exp_sel);
      check("cyc_pin_owned", 64'(bus.pin_owned), 64'(exp_own));
    end
  end

  // ---------------- directed stimulus ----------------
  logic got_ok  [4];
  int   got_cyc [4];

  task automatic run_batch(input logic [3:0] mask, input logic [7:0] ops, input logic [19:0] pins);
    logic [3:0] pending;
    pending       = mask;
    bus.req_op    = ops;
    bus.req_pin   = pins;
    bus.req_valid = mask;
    for (int c = 0; c < 4; c++) begin got_ok[c] = 1'bx; got_cyc[c] = -1; end
    for (int i = 1; i <= 40 && pending != 0; i++) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
        if (pending[c] && bus.resp_valid[c]) begin
          got_ok[c]        = bus.resp_ok[c];
          got_cyc[c]       = i;
          pending[c]       = 1'b0;
          bus.req_valid[c] = 1'b0;
        end
      end
    end
    if (pending != 0) begin
      check("batch_timeout_pending", 64'(pending), 64'd0);
      bus.req_valid = '0;
    end
  endtask

  task automatic req1(input int core, input logic [1:0] op, input logic [4:0] pin);
    logic [7:0]  o;
    logic [19:0] pv;
    o = '0; pv = '0;
    o[core*2 +: 2]  = op;
    pv[core*5 +: 5] = pin;
    run_batch(4'(1 << core), o, pv);
  endtask

  initial begin
    int order [$];
    int when  [$];
    int exp_order [5] = '{0, 1, 2, 3, 0};

    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_pin   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_core_select", bus.core_select, 64'd0);
    check("reset_pin_owned", 64'(bus.pin_owned), 64'd0);
    check("reset_resp_valid", 64'(bus.resp_valid), 64'd0);

    // Cores 0 and 2 race for pin 3 with rr_ptr=0.
    run_batch(4'b0101, 8'h00, {5'd0, 5'd3, 5'd0, 5'd3});
    check("race_c0_ok", 64'(got_ok[0]), 64'd1);
    check("race_c0_lat", 64'(got_cyc[0]), 64'd2);
    check("race_c2_ok", 64'(got_ok[2]), 64'd0);
    check("race_c2_lat", 64'(got_cyc[2]), 64'd4);
    check("race_owned", 64'(bus.pin_owned), 64'h8);
    check("race_select", bus.core_select, 64'd0);

    // Core 3 query moves the pointer back to 0.
    req1(3, 2'b11, 5'd3);
    check("q3_ok", 64'(got_ok[3]), 64'd0);

    // All four cores hold valid with queries.
    bus.req_op    = 8'hFF;
    bus.req_pin   = {4{5'd3}};
    bus.req_valid = 4'hF;
    for (int i = 1; i <= 30 && order.size() < 5; i++) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++)
        if (bus.resp_valid[c]) begin order.push_back(c); when.push_back(i); end
      if (order.size() >= 5) bus.req_valid = '0;
    end
    bus.req_valid = '0;
    check("stream_count", 64'(order.size()), 64'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < order.size()) begin
        check("stream_order", 64'(order[k]), 64'(exp_order[k]));
        check("stream_spacing", 64'(when[k]), 64'(2 + 2*k));
      end
    end

    // Core 1 claims pin 7, then pin 9.
    req1(1, 2'b00, 5'd7);
    check("claim7_ok", 64'(got_ok[1]), 64'd1);
    check("claim7_lat", 64'(got_cyc[1]), 64'd2);
    check("claim7_sel", 64'(bus.core_select[15:14]), 64'd1);
    check("claim7_owned", 64'(bus.pin_owned), 64'h88);
    req1(1, 2'b00, 5'd9);
    check("claim9_ok", 64'(got_ok[1]), 64'd1);

    // Core 3 cannot release core 1's pin.
    req1(3, 2'b01, 5'd7);
    check("rel_foreign_ok", 64'(got_ok[3]), 64'd0);
    check("rel_foreign_owned", 64'(bus.pin_owned), 64'h288);

    req1(1, 2'b10, 5'd0);
    check("relall_ok", 64'(got_ok[1]), 64'd1);
    check("relall_owned", 64'(bus.pin_owned), 64'h8);
    check("relall_select", bus.core_select, 64'd0);

    // Idempotent claim of pin 31 by core 2, then queries.
    req1(2, 2'b00, 5'd31);
    check("claim31a_ok", 64'(got_ok[2]), 64'd1);
    req1(2, 2'b00, 5'd31);
    check("claim31b_ok", 64'(got_ok[2]), 64'd1);
    req1(2, 2'b11, 5'd31);
    check("query31_c2", 64'(got_ok[2]), 64'd1);
    req1(0, 2'b11, 5'd31);
    check("query31_c0", 64'(got_ok[0]), 64'd0);
    check("pin31_select", bus.core_select, 64'h8000_0000_0000_0000);
    check("pin31_owned", 64'(bus.pin_owned), 64'h8000_0008);

    req1(0, 2'b01, 5'd3);
    check("rel3_ok", 64'(got_ok[0]), 64'd1);
    check("rel3_owned", 64'(bus.pin_owned), 64'h8000_0000);

    // Reset while a claim sits in the commit cycle.
    bus.req_op    = 8'h00;
    bus.req_pin   = 20'(5) << 5;
    bus.req_valid = 4'b0010;
    @(negedge clk);
    rst           = 1'b1;
    bus.req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midreset_no_resp", 64'(bus.resp_valid), 64'd0);
    end
    check("midreset_owned", 64'(bus.pin_owned), 64'd0);
    check("midreset_select", bus.core_select, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
